// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: FSM state encoding,
// width helpers and the rotating-priority search used by the picker.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Upper bound on requesters the generic search function handles.
  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int width_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid[0 +: n], searching upward from start and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int n, input int start);
    rr_pick_t r;
    int       cand;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = start + k;
      if (cand >= n) cand = cand - n;
      if (k < n && !r.found && valid[cand[MAX_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority encoder: first valid requester at or above
// start, wrapping modulo N_REQ (explicit compare, so any N_REQ works).
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDX_W = width_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  assign valid_ext = MAX_REQ'(valid);

  always_comb begin
    pick = rr_pick(valid_ext, N_REQ, int'(start));
  end

  assign found = pick.found;
  assign idx   = IDX_W'(pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-holding arbiter for the async FIFO write port. A grant
// lasts until the owner's last beat or MAX_BURST beats, then one idle cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic [N_REQ-1:0]            i_Req_Valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_Req_Data,
  input  logic [N_REQ-1:0]            i_Req_Last,
  output logic [N_REQ-1:0]            o_Req_Ready,
  input  logic                        i_Fifo_Full,
  output logic                        o_Fifo_W_en,
  output logic [DATA_WIDTH-1:0]       o_Fifo_Data,
  output logic [N_REQ-1:0]            o_Grant,
  output logic                        o_Busy
);

  // Handshake: a beat moves when valid and ready are both high in the same
  // cycle; ready is only ever raised for the owner and only when the FIFO is
  // not full, so a requester must hold valid/data/last steady until ready.

  localparam int                IDX_W     = width_min1(N_REQ);
  localparam int                BEAT_W    = width_min1(MAX_BURST);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                xfer;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .valid (i_Req_Valid),
    .start (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    xfer        = 1'b0;
    o_Fifo_W_en = 1'b0;
    o_Req_Ready = '0;
    o_Grant     = '0;
    o_Busy      = 1'b0;
    // Data path is a plain mux on the owner; W_en alone qualifies it.
    o_Fifo_Data = i_Req_Data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        o_Busy               = 1'b1;
        o_Grant[owner_q]     = 1'b1;
        xfer                 = i_Req_Valid[owner_q] & ~i_Fifo_Full;
        o_Fifo_W_en          = xfer;
        o_Req_Ready[owner_q] = xfer;
        if (xfer) begin
          // Last beat and burst cap in the same beat collapse into one exit.
          if (i_Req_Last[owner_q] || beat_cnt_q == BEAT_LAST) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
